// File: rtl/l2_mp_log_buffer.sv
// l2_mp_log_buffer: timestamps main-pipe records, optionally filters by set, and buffers them for the log writer
module l2_mp_log_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [2:0]                 in_metaWway,
  input  logic                       in_metaWvalid,
  input  logic [7:0]                 in_mshrId,
  input  logic [7:0]                 in_allocPtr,
  input  logic                       in_allocValid,
  input  logic [2:0]                 in_dirWay,
  input  logic                       in_dirHit,
  input  logic [8:0]                 in_sset,
  input  logic [18:0]                in_tag,
  input  logic [2:0]                 in_opcode,
  input  logic [2:0]                 in_channel,
  input  logic                       in_mshrTask,
  input  logic                       filter_en,
  input  logic [8:0]                 filter_set,
  input  logic                       out_ready,
  output logic                       out_en,
  output logic [2:0]                 out_metaWway,
  output logic                       out_metaWvalid,
  output logic [7:0]                 out_mshrId,
  output logic [7:0]                 out_allocPtr,
  output logic                       out_allocValid,
  output logic [2:0]                 out_dirWay,
  output logic                       out_dirHit,
  output logic [8:0]                 out_sset,
  output logic [18:0]                out_tag,
  output logic [2:0]                 out_opcode,
  output logic [2:0]                 out_channel,
  output logic                       out_mshrTask,
  output logic [63:0]                out_stamp,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 124;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [RW-1:0]    mem_q [DEPTH];
  logic [RW-1:0]    last_q, in_rec, head;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      occ_q, occ_d;
  logic [63:0]      now_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, push, acc, drop;
  assign in_rec = {in_metaWway, in_metaWvalid, in_mshrId, in_allocPtr, in_allocValid, in_dirWay,
                   in_dirHit, in_sset, in_tag, in_opcode, in_channel, in_mshrTask, now_q};
  assign push   = in_valid && (!filter_en || in_sset == filter_set);
  assign out_en = occ_q != '0 && out_ready;
  assign acc    = push && (occ_q != FULL || out_en);
  assign drop   = push && !acc;
  // Head is shown while non-empty; once drained the last popped record is held.
  assign head   = occ_q != '0 ? mem_q[rd_q] : last_q;
  assign {out_metaWway, out_metaWvalid, out_mshrId, out_allocPtr, out_allocValid, out_dirWay,
          out_dirHit, out_sset, out_tag, out_opcode, out_channel, out_mshrTask, out_stamp} = head;
  assign drop_cnt  = cnt_q;
  assign overflow  = ovf_q;
  assign occupancy = occ_q;
  always_comb begin
    occ_d = occ_q + (AW+1)'(acc) - (AW+1)'(out_en);
    cnt_d = drop && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      now_q  <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      now_q <= now_q + 64'd1;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_q | drop;
      if (acc) wr_q <= wr_q + AW'(1);
      if (out_en) begin
        rd_q   <= rd_q + AW'(1);
        last_q <= mem_q[rd_q];
      end
    end
  end
  always_ff @(posedge clock)
    if (acc && !reset) mem_q[wr_q] <= in_rec;
endmodule

// File: tb/tb_l2_mp_log_buffer.sv
// tb_l2_mp_log_buffer: directed checks of the log buffer; a second instance with a 2-bit drop counter covers saturation
module tb_l2_mp_log_buffer;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [2:0] in_metaWway = '0, in_dirWay = '0, in_opcode = '0, in_channel = '0;
  logic in_metaWvalid = 1'b0, in_allocValid = 1'b0, in_dirHit = 1'b0, in_mshrTask = 1'b0;
  logic [7:0] in_mshrId = '0, in_allocPtr = '0;
  logic [8:0] in_sset = '0, filter_set = '0;
  logic [18:0] in_tag = '0;
  logic filter_en = 1'b0, out_ready = 1'b0;
  logic out_en, out_metaWvalid, out_allocValid, out_dirHit, out_mshrTask, overflow;
  logic [2:0] out_metaWway, out_dirWay, out_opcode, out_channel;
  logic [7:0] out_mshrId, out_allocPtr;
  logic [8:0] out_sset;
  logic [18:0] out_tag;
  logic [63:0] out_stamp;
  logic [15:0] drop_cnt;
  logic [3:0] occupancy;
  logic s_en, s_metaWvalid, s_allocValid, s_dirHit, s_mshrTask, s_overflow;
  logic [2:0] s_metaWway, s_dirWay, s_opcode, s_channel;
  logic [7:0] s_mshrId, s_allocPtr;
  logic [8:0] s_sset;
  logic [18:0] s_tag;
  logic [63:0] s_stamp;
  logic [1:0] s_drop;
  logic [3:0] s_occ;
  logic [63:0] cyc = '0;
  int tests = 0, failed = 0, pulses = 0;

  l2_mp_log_buffer #(.DEPTH(8), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_metaWway(in_metaWway),
    .in_metaWvalid(in_metaWvalid), .in_mshrId(in_mshrId), .in_allocPtr(in_allocPtr),
    .in_allocValid(in_allocValid), .in_dirWay(in_dirWay), .in_dirHit(in_dirHit), .in_sset(in_sset),
    .in_tag(in_tag), .in_opcode(in_opcode), .in_channel(in_channel), .in_mshrTask(in_mshrTask),
    .filter_en(filter_en), .filter_set(filter_set), .out_ready(out_ready), .out_en(out_en),
    .out_metaWway(out_metaWway), .out_metaWvalid(out_metaWvalid), .out_mshrId(out_mshrId),
    .out_allocPtr(out_allocPtr), .out_allocValid(out_allocValid), .out_dirWay(out_dirWay),
    .out_dirHit(out_dirHit), .out_sset(out_sset), .out_tag(out_tag), .out_opcode(out_opcode),
    .out_channel(out_channel), .out_mshrTask(out_mshrTask), .out_stamp(out_stamp),
    .drop_cnt(drop_cnt), .overflow(overflow), .occupancy(occupancy)
  );

  l2_mp_log_buffer #(.DEPTH(8), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_metaWway(in_metaWway),
    .in_metaWvalid(in_metaWvalid), .in_mshrId(in_mshrId), .in_allocPtr(in_allocPtr),
    .in_allocValid(in_allocValid), .in_dirWay(in_dirWay), .in_dirHit(in_dirHit), .in_sset(in_sset),
    .in_tag(in_tag), .in_opcode(in_opcode), .in_channel(in_channel), .in_mshrTask(in_mshrTask),
    .filter_en(filter_en), .filter_set(filter_set), .out_ready(out_ready), .out_en(s_en),
    .out_metaWway(s_metaWway), .out_metaWvalid(s_metaWvalid), .out_mshrId(s_mshrId),
    .out_allocPtr(s_allocPtr), .out_allocValid(s_allocValid), .out_dirWay(s_dirWay),
    .out_dirHit(s_dirHit), .out_sset(s_sset), .out_tag(s_tag), .out_opcode(s_opcode),
    .out_channel(s_channel), .out_mshrTask(s_mshrTask), .out_stamp(s_stamp),
    .drop_cnt(s_drop), .overflow(s_overflow), .occupancy(s_occ)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= reset ? 64'd0 : cyc + 64'd1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_en", 64'(out_en), 0);
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_stamp", out_stamp, 0);
    chk("rst_tag", 64'(out_tag), 0);
    while (cyc != 64'd10) tick();
    in_metaWway = 3'd5; in_metaWvalid = 1'b1; in_mshrId = 8'hA7; in_allocPtr = 8'h3C;
    in_allocValid = 1'b1; in_dirWay = 3'd6; in_dirHit = 1'b1; in_sset = 9'h1A5;
    in_tag = 19'h7FFFF; in_opcode = 3'd4; in_channel = 3'd3; in_mshrTask = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("pt_out_en", 64'(out_en), 1);
    chk("pt_stamp", out_stamp, 10);
    chk("pt_sset", 64'(out_sset), 64'h1A5);
    chk("pt_tag", 64'(out_tag), 64'h7FFFF);
    chk("pt_opcode", 64'(out_opcode), 4);
    chk("pt_mshrId", 64'(out_mshrId), 64'hA7);
    chk("pt_allocPtr", 64'(out_allocPtr), 64'h3C);
    chk("pt_ways", 64'({out_metaWway, out_dirWay, out_channel}), 64'({3'd5, 3'd6, 3'd3}));
    chk("pt_bits", 64'({out_metaWvalid, out_allocValid, out_dirHit, out_mshrTask}), 64'hF);
    chk("pt_occ", 64'(occupancy), 1);
    tick();
    #1;
    chk("pt_occ_after", 64'(occupancy), 0);
    chk("pt_en_after", 64'(out_en), 0);
    chk("pt_hold_sset", 64'(out_sset), 64'h1A5);

    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_tag = 19'(i);
      in_sset = 9'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("bp_occ", 64'(occupancy), 8);
    chk("bp_drop", 64'(drop_cnt), 2);
    chk("bp_ovf", 64'(overflow), 1);
    chk("bp_sat_drop2", 64'(s_drop), 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_tag = 19'(100 + i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("bp_drop7", 64'(drop_cnt), 7);
    chk("sat_hold", 64'(s_drop), 3);
    chk("sat_ovf", 64'(s_overflow), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("drain_en", 64'(out_en), 1);
      chk("drain_tag", 64'(out_tag), 64'(k));
      chk("drain_stamp", out_stamp, 64'(k));
      tick();
    end
    #1;
    chk("drain_empty_en", 64'(out_en), 0);
    chk("drain_empty_occ", 64'(occupancy), 0);

    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_tag = 19'(256 + i);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_tag = 19'h200;
    #1;
    chk("fp_en", 64'(out_en), 1);
    chk("fp_head", 64'(out_tag), 64'h100);
    tick();
    in_valid = 1'b0;
    #1;
    chk("fp_occ", 64'(occupancy), 8);
    chk("fp_drop", 64'(drop_cnt), 7);
    chk("fp_next", 64'(out_tag), 64'h101);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    #1;
    chk("mid_occ5", 64'(occupancy), 5);

    reset = 1'b1;
    in_valid = 1'b1;
    in_tag = 19'h3AB;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_en", 64'(out_en), 0);
    chk("mr_occ", 64'(occupancy), 0);
    chk("mr_drop", 64'(drop_cnt), 0);
    chk("mr_ovf", 64'(overflow), 0);
    chk("mr_sat_drop", 64'(s_drop), 0);
    tick();
    tick();
    in_valid = 1'b1;
    in_tag = 19'h44;
    tick();
    in_valid = 1'b0;
    #1;
    chk("mr_push_en", 64'(out_en), 1);
    chk("mr_push_tag", 64'(out_tag), 64'h44);
    chk("mr_push_stamp", out_stamp, 2);
    tick();

    filter_en = 1'b1;
    filter_set = 9'h055;
    for (int i = 0; i < 6; i++) begin
      in_valid = i < 3;
      in_sset = i == 1 ? 9'h056 : 9'h055;
      in_tag = 19'(1280 + i);
      #1;
      if (out_en) begin
        pulses++;
        chk("flt_sset", 64'(out_sset), 64'h055);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("flt_pulses", 64'(pulses), 2);
    chk("flt_drop", 64'(drop_cnt), 0);
    chk("flt_occ", 64'(occupancy), 0);
    chk("flt_last_tag", 64'(out_tag), 64'(1282));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/l2_mp_log_buffer.md
# l2_mp_log_buffer

Capture-and-drain stage sitting directly upstream of the L2 main-pipe DPI log writer. Samples one main-pipe record per cycle and attaches a 64-bit cycle timestamp. Optionally filters records by set index, buffers them in a small FIFO, and presents them one per cycle as a writer-enable plus record bundle. Decouples main-pipe timing from logging back-pressure and counts records lost to overflow.

## Interface

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CNT_W, 16, width of the drop counter.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  main pipe presents a record this cycle.
- in_metaWway  in  3 / in_metaWvalid  in  1 / in_mshrId  in  8 / in_allocPtr  in  8 / in_allocValid  in  1 / in_dirWay  in  3 / in_dirHit  in  1 / in_sset  in  9 / in_tag  in  19 / in_opcode  in  3 / in_channel  in  3 / in_mshrTask  in  1  record fields.
- filter_en  in  1  when 1, only records with in_sset == filter_set are logged.
- filter_set  in  9  set index for filtering.
- out_ready  in  1  log sink can take a record this cycle.
- out_en  out  1  record on out_* is valid and consumed this cycle.
- out_<field>  out  same widths as in_<field>  head-of-FIFO record.
- out_stamp  out  64  cycle timestamp of the head record.
- drop_cnt  out  CNT_W  records dropped because the FIFO was full; saturates at all-ones.
- overflow  out  1  sticky; set on the first drop.
- occupancy  out  log2(DEPTH)+1  current FIFO entry count.

## Operation

- Cycle counter `now`: 64 bits, 0 after reset, +1 every cycle, wraps modulo 2^64.
- Qualified push: `push = in_valid && (!filter_en || in_sset == filter_set)`. Unqualified records are silently ignored and are not counted as drops.
- Stored stamp is the value of `now` in the cycle in_valid is sampled.
- Pop: `out_en = (occupancy != 0) && out_ready`. While out_en is 1, out_* carry the head entry, and the head is removed at the clock edge.
- Accept rule: a push is accepted if `occupancy < DEPTH`, or if `occupancy == DEPTH` and a pop happens the same cycle.
- Drop rule: a push that cannot be accepted does not write. Instead, drop_cnt increments (saturating) and overflow sets.
- Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH.
- out_* field values when out_en=0 are don't-care for the sink. The implementation drives the head entry and holds the last value when empty.
- filter_en and filter_set take effect in the cycle they are applied; no pipelining.

## Timing

- Reset values: out_en=0, occupancy=0, drop_cnt=0, overflow=0, `now`=0, out_* data=0, read/write pointers=0.
- Reset is synchronous. Asserting reset mid-operation discards all buffered entries at that edge. A push in the reset cycle is not stored and not counted.
- Latency: a record pushed in cycle t into an empty FIFO appears on out_* with out_en=1 in cycle t+1, provided out_ready=1 then. There is no combinational path from in_* to out_*.
- Throughput: one push and one pop per cycle, sustained.
- out_en depends combinationally only on registered occupancy and out_ready.
- Full: occupancy==DEPTH and out_ready=0 drop every qualified push. Occupancy==DEPTH with out_ready=1 accepts the push and pops the head.
- Empty with out_ready=1: out_en=0, and nothing is popped.
- drop_cnt saturation: once drop_cnt is all-ones, it holds. overflow stays 1 until reset.

## Test plan

- Basic pass-through: reset, out_ready=1. Push one record (sset=0x1A5, tag=0x7FFFF, opcode=4) in cycle 10 → out_en=1 in cycle 11 with identical fields and out_stamp=10. occupancy returns to 0 in cycle 12.
- Back-pressure fill: out_ready=0, push 10 records in cycles 0–9 with DEPTH=8 → occupancy=8, drop_cnt=2, overflow=1. Then raise out_ready → 8 pops in order, stamps 0..7.
- Full with simultaneous pop: occupancy=8, out_ready=1, push in the same cycle → push accepted, occupancy stays 8, drop_cnt unchanged.
- Filter: filter_en=1, filter_set=0x055. Push sset 0x055, 0x056, 0x055 on consecutive cycles → exactly 2 out_en pulses with sset=0x055. drop_cnt stays 0.
- Saturation: CNT_W=2 with a full FIFO held and 5 drop attempts → drop_cnt=3 and holds.
- Reset mid-operation: occupancy=5, assert reset one cycle → next cycle out_en=0, occupancy=0, drop_cnt=0, overflow=0. The next push is stamped relative to `now` restarting at 0.
